// File: rtl/pika_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, instruction
// class flag positions and the NZCV flag width.
package pika_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

  localparam int CLS_ALU = 0;
  localparam int CLS_CMP = 1;
  localparam int CLS_LD  = 2;
  localparam int CLS_STR = 3;
  localparam int CLS_W   = 4;

  localparam int NZCV_W  = 4;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Request/grant data-memory bus; the pipeline stage is the master and the
// memory is the slave.
interface memory_stage_if #(
  parameter int AW = 32
) ();

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Cycle counter bounding the time a transaction may spend in REQ plus WAIT;
// expired is high during the last permitted cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Next count: clear wins, then saturating increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: retires ALU/compare ops directly and runs load/store
// transactions against the data memory under a cycle-bounded timeout.
module memory_stage
  import pika_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       result,
  input  logic [3:0]        rd_num,
  input  logic [31:0]       rd_val,
  input  logic [31:0]       md,
  input  logic              is_alu_op,
  input  logic              is_cmp_op,
  input  logic              is_ld_op,
  input  logic              is_str_op,
  input  logic [31:0]       cpsr,
  memory_stage_if.master    dmem,
  output logic              wb_valid,
  output logic              wb_reg_we,
  output logic [3:0]        wb_rd_num,
  output logic [31:0]       wb_data,
  output logic              wb_cpsr_we,
  output logic [NZCV_W-1:0] wb_cpsr,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic              ex_ready_q, ex_ready_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [AW-1:0]     dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        rd_lat_q, rd_lat_d;
  logic              is_ld_q, is_ld_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_we_q, wb_reg_we_d;
  logic [3:0]        wb_rd_num_q, wb_rd_num_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_cpsr_we_q, wb_cpsr_we_d;
  logic [NZCV_W-1:0] wb_cpsr_q, wb_cpsr_d;
  logic              mem_err_q, mem_err_d;

  logic [CLS_W-1:0]  cls_s;
  logic              ctr_clr_s;
  logic              ctr_en_s;
  logic              ctr_expired_s;
  logic              cpsr_unused;

  assign cls_s[CLS_ALU] = is_alu_op;
  assign cls_s[CLS_CMP] = is_cmp_op;
  assign cls_s[CLS_LD]  = is_ld_op;
  assign cls_s[CLS_STR] = is_str_op;
  assign cpsr_unused    = ^cpsr[31:NZCV_W];
  assign ctr_en_s       = (state_q == ST_REQ) || (state_q == ST_WAIT);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr_s),
    .en      (ctr_en_s),
    .expired (ctr_expired_s)
  );

  // Next-state and next-output logic; write-back fields are single-cycle pulses.
  always_comb begin
    state_d      = state_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rd_lat_d     = rd_lat_q;
    is_ld_d      = is_ld_q;
    wb_valid_d   = 1'b0;
    wb_reg_we_d  = 1'b0;
    wb_rd_num_d  = 4'h0;
    wb_data_d    = 32'h0000_0000;
    wb_cpsr_we_d = 1'b0;
    wb_cpsr_d    = {NZCV_W{1'b0}};
    mem_err_d    = 1'b0;
    ctr_clr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ex_valid) begin
          state_d = ST_IDLE;
        end else if (cls_s[CLS_LD] || cls_s[CLS_STR]) begin
          if (is_misaligned(md[1:0])) begin
            wb_valid_d = 1'b1;
            mem_err_d  = 1'b1;
          end else begin
            state_d      = ST_REQ;
            ctr_clr_s    = 1'b1;
            dmem_addr_d  = md[AW-1:0];
            dmem_wdata_d = rd_val;
            rd_lat_d     = rd_num;
            is_ld_d      = cls_s[CLS_LD];
            dmem_we_d    = ~cls_s[CLS_LD];
          end
        end else if (cls_s[CLS_ALU]) begin
          wb_valid_d  = 1'b1;
          wb_reg_we_d = 1'b1;
          wb_rd_num_d = rd_num;
          wb_data_d   = result;
        end else if (cls_s[CLS_CMP]) begin
          wb_valid_d   = 1'b1;
          wb_cpsr_we_d = 1'b1;
          wb_cpsr_d    = cpsr[NZCV_W-1:0];
        end else begin
          wb_valid_d = 1'b1;
        end
      end
      ST_REQ: begin
        // A load granted on its last permitted cycle without data cannot wait.
        if (dmem.dmem_gnt && !is_ld_q) begin
          state_d    = ST_RESP;
          wb_valid_d = 1'b1;
        end else if (dmem.dmem_gnt && dmem.dmem_rvalid) begin
          state_d     = ST_RESP;
          wb_valid_d  = 1'b1;
          wb_reg_we_d = 1'b1;
          wb_rd_num_d = rd_lat_q;
          wb_data_d   = dmem.dmem_rdata;
        end else if (ctr_expired_s) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          mem_err_d  = 1'b1;
        end else if (dmem.dmem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d     = ST_RESP;
          wb_valid_d  = 1'b1;
          wb_reg_we_d = 1'b1;
          wb_rd_num_d = rd_lat_q;
          wb_data_d   = dmem.dmem_rdata;
        end else if (ctr_expired_s) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          mem_err_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ex_ready_d = (state_d == ST_IDLE);
    dmem_req_d = (state_d == ST_REQ);
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ex_ready_q   <= 1'b1;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= {AW{1'b0}};
      dmem_wdata_q <= 32'h0000_0000;
      rd_lat_q     <= 4'h0;
      is_ld_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_reg_we_q  <= 1'b0;
      wb_rd_num_q  <= 4'h0;
      wb_data_q    <= 32'h0000_0000;
      wb_cpsr_we_q <= 1'b0;
      wb_cpsr_q    <= {NZCV_W{1'b0}};
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ex_ready_q   <= ex_ready_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rd_lat_q     <= rd_lat_d;
      is_ld_q      <= is_ld_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_we_q  <= wb_reg_we_d;
      wb_rd_num_q  <= wb_rd_num_d;
      wb_data_q    <= wb_data_d;
      wb_cpsr_we_q <= wb_cpsr_we_d;
      wb_cpsr_q    <= wb_cpsr_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign ex_ready        = ex_ready_q;
  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_reg_we       = wb_reg_we_q;
  assign wb_rd_num       = wb_rd_num_q;
  assign wb_data         = wb_data_q;
  assign wb_cpsr_we      = wb_cpsr_we_q;
  assign wb_cpsr         = wb_cpsr_q;
  assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// transactions compared against a cycle-level outcome model.
module tb_memory_stage;
  import pika_pkg::*;

  localparam int TO  = 8;
  localparam int WIN = TO + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] result = 32'h0;
  logic [3:0]  rd_num = 4'h0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] md = 32'h0;
  logic        is_alu_op = 1'b0, is_cmp_op = 1'b0, is_ld_op = 1'b0, is_str_op = 1'b0;
  logic [31:0] cpsr = 32'h0;
  logic        wb_valid, wb_reg_we, wb_cpsr_we, mem_err;
  logic [3:0]  wb_rd_num, wb_cpsr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  memory_stage_if #(.AW(32)) dmem_bus ();

  memory_stage #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .result(result), .rd_num(rd_num), .rd_val(rd_val), .md(md),
    .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_ld_op(is_ld_op), .is_str_op(is_str_op),
    .cpsr(cpsr), .dmem(dmem_bus.master),
    .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_rd_num(wb_rd_num), .wb_data(wb_data),
    .wb_cpsr_we(wb_cpsr_we), .wb_cpsr(wb_cpsr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wb_cyc, wb_n, err_cyc, err_n, req_n;
    logic        reg_we, cpsr_we, we0, ready_start, ready_end;
    logic [31:0] data, a0, w0;
    logic [3:0]  rd, cpsr;
    bit          unstable, leak;
  } obs_t;

  typedef struct {
    int          wb_cyc, err_cyc, req_n;
    logic        reg_we, cpsr_we;
    logic [31:0] data;
    logic [3:0]  rd, cpsr;
  } exp_t;

  // cls: 0 alu, 1 cmp, 2 load, 3 store, 4 no class. Cycles count from the accepting edge.
  function automatic exp_t model(input int cls, input logic [31:0] res, input logic [3:0] rd,
                                 input logic [31:0] addr, input logic [31:0] cp,
                                 input int gd, input int rv, input logic [31:0] rdat);
    exp_t e;
    int   g;
    e.wb_cyc = 1; e.err_cyc = -1; e.req_n = 0; e.reg_we = 1'b0; e.cpsr_we = 1'b0;
    e.data = 32'h0; e.rd = 4'h0; e.cpsr = 4'h0;
    if (cls == 2 || cls == 3) begin
      g = gd + 1;
      if (addr[1:0] != 2'b00) begin
        e.err_cyc = 1;
      end else if (g > TO) begin
        e.req_n = TO; e.wb_cyc = TO + 1; e.err_cyc = TO + 1;
      end else if (cls == 3) begin
        e.req_n = g; e.wb_cyc = g + 1;
      end else if (rv < 0 || g + rv > TO) begin
        e.req_n = g; e.wb_cyc = TO + 1; e.err_cyc = TO + 1;
      end else begin
        e.req_n = g; e.wb_cyc = g + rv + 1; e.reg_we = 1'b1; e.data = rdat; e.rd = rd;
      end
    end else if (cls == 0) begin
      e.reg_we = 1'b1; e.data = res; e.rd = rd;
    end else if (cls == 1) begin
      e.cpsr_we = 1'b1; e.cpsr = cp[3:0];
    end
    return e;
  endfunction

  // Presents one instruction, plays the memory side, and records what the DUT did.
  task automatic drive_txn(input int cls, input logic [31:0] res, input logic [3:0] rd,
                           input logic [31:0] rdv, input logic [31:0] addr, input logic [31:0] cp,
                           input int gd, input int rv, input logic [31:0] rdat, input bit stray,
                           output obs_t o);
    int req_n;
    int gnt_k;
    o.wb_cyc = -1; o.wb_n = 0; o.err_cyc = -1; o.err_n = 0; o.req_n = 0;
    o.reg_we = 1'b0; o.cpsr_we = 1'b0; o.we0 = 1'b0; o.data = 32'h0; o.a0 = 32'h0; o.w0 = 32'h0;
    o.rd = 4'h0; o.cpsr = 4'h0; o.unstable = 1'b0; o.leak = 1'b0;
    o.ready_start = ex_ready;
    ex_valid = 1'b1; result = res; rd_num = rd; rd_val = rdv; md = addr; cpsr = cp;
    is_alu_op = (cls == 0); is_cmp_op = (cls == 1); is_ld_op = (cls == 2); is_str_op = (cls == 3);
    dmem_bus.dmem_gnt = stray; dmem_bus.dmem_rvalid = stray; dmem_bus.dmem_rdata = rdat;
    @(posedge clk); #1;
    ex_valid = 1'b0; is_alu_op = 1'b0; is_cmp_op = 1'b0; is_ld_op = 1'b0; is_str_op = 1'b0;
    result = $urandom; md = $urandom; rd_val = $urandom; rd_num = 4'($urandom);
    req_n = 0; gnt_k = -1;
    for (int k = 1; k <= WIN; k++) begin
      if (wb_valid) begin
        o.wb_n++;
        if (o.wb_cyc < 0) begin
          o.wb_cyc = k; o.reg_we = wb_reg_we; o.cpsr_we = wb_cpsr_we;
          o.data = wb_data; o.rd = wb_rd_num; o.cpsr = wb_cpsr;
        end
      end else if (wb_reg_we || wb_cpsr_we) begin
        o.leak = 1'b1;
      end
      if (mem_err) begin
        o.err_n++;
        if (o.err_cyc < 0) o.err_cyc = k;
      end
      if (dmem_bus.dmem_req) begin
        if (req_n == 0) begin
          o.a0 = dmem_bus.dmem_addr; o.w0 = dmem_bus.dmem_wdata; o.we0 = dmem_bus.dmem_we;
        end else if (dmem_bus.dmem_addr !== o.a0 || dmem_bus.dmem_wdata !== o.w0 ||
                     dmem_bus.dmem_we !== o.we0) begin
          o.unstable = 1'b1;
        end
        req_n++;
      end
      dmem_bus.dmem_gnt = stray || (dmem_bus.dmem_req && (req_n - 1 == gd));
      if (dmem_bus.dmem_gnt && !stray) gnt_k = k;
      dmem_bus.dmem_rvalid = stray || (gnt_k > 0 && rv >= 0 && k == gnt_k + rv);
      @(posedge clk); #1;
    end
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    o.req_n = req_n;
    o.ready_end = ex_ready;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    total++; if (dmem_bus.dmem_req !== 1'b0) begin bad++; $display("FAIL reset_dmem_req: got %b want 0", dmem_bus.dmem_req); end
    total++; if ({wb_valid, wb_reg_we, wb_cpsr_we, mem_err} !== 4'b0000) begin bad++; $display("FAIL reset_pulses: got %b want 0000", {wb_valid, wb_reg_we, wb_cpsr_we, mem_err}); end
    total++; if ({dmem_bus.dmem_addr, dmem_bus.dmem_wdata, wb_data} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {dmem_bus.dmem_addr, dmem_bus.dmem_wdata, wb_data}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    obs_t o;
    drive_txn(0, 32'h0000_00AA, 4'd3, 32'h0, 32'h0, 32'h0, 0, -1, 32'h5555_5555, 1'b1, o);
    total++; if (o.wb_cyc !== 1) begin bad++; $display("FAIL alu_latency: got %0d want 1", o.wb_cyc); end
    total++; if (o.reg_we !== 1'b1) begin bad++; $display("FAIL alu_reg_we: got %b want 1", o.reg_we); end
    total++; if (o.rd !== 4'd3) begin bad++; $display("FAIL alu_rd: got %0d want 3", o.rd); end
    total++; if (o.data !== 32'h0000_00AA) begin bad++; $display("FAIL alu_data: got %h want 000000aa", o.data); end
    total++; if (o.wb_n !== 1 || o.req_n !== 0 || o.err_n !== 0) begin bad++; $display("FAIL alu_side: got wb=%0d req=%0d err=%0d want 1 0 0", o.wb_n, o.req_n, o.err_n); end
  endtask

  task automatic test_random_simple();
    obs_t o;
    exp_t e;
    int cls;
    logic [31:0] r, c;
    logic [3:0] d;
    for (int i = 0; i < 24; i++) begin
      cls = int'($urandom_range(0, 2));
      if (cls == 2) cls = 4;
      r = $urandom; c = $urandom; d = 4'($urandom);
      e = model(cls, r, d, 32'h0, c, 0, -1, 32'h0);
      drive_txn(cls, r, d, 32'h0, 32'h0, c, 0, -1, 32'h0, 1'b0, o);
      total++; if (o.wb_cyc !== e.wb_cyc || o.wb_n !== 1) begin bad++; $display("FAIL simple_wb[%0d]: got cyc=%0d n=%0d want cyc=%0d n=1", i, o.wb_cyc, o.wb_n, e.wb_cyc); end
      total++; if ({o.reg_we, o.cpsr_we} !== {e.reg_we, e.cpsr_we}) begin bad++; $display("FAIL simple_we[%0d]: got %b%b want %b%b", i, o.reg_we, o.cpsr_we, e.reg_we, e.cpsr_we); end
      if (e.reg_we) begin
        total++; if ({o.rd, o.data} !== {e.rd, e.data}) begin bad++; $display("FAIL simple_data[%0d]: got %h/%h want %h/%h", i, o.rd, o.data, e.rd, e.data); end
      end
      if (e.cpsr_we) begin
        total++; if (o.cpsr !== e.cpsr) begin bad++; $display("FAIL simple_cpsr[%0d]: got %h want %h", i, o.cpsr, e.cpsr); end
      end
      total++; if (o.err_n !== 0 || o.req_n !== 0 || o.leak) begin bad++; $display("FAIL simple_side[%0d]: got err=%0d req=%0d leak=%b want 0 0 0", i, o.err_n, o.req_n, o.leak); end
    end
  endtask

  task automatic test_store();
    obs_t o;
    drive_txn(3, 32'h0, 4'd7, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0, 3, -1, 32'h0, 1'b0, o);
    total++; if (o.ready_start !== 1'b1) begin bad++; $display("FAIL store_ready: got %b want 1", o.ready_start); end
    total++; if (o.req_n !== 4) begin bad++; $display("FAIL store_req_cycles: got %0d want 4", o.req_n); end
    total++; if (o.unstable) begin bad++; $display("FAIL store_stable: got unstable=1 want 0"); end
    total++; if ({o.a0, o.w0, o.we0} !== {32'h0000_0100, 32'hDEAD_BEEF, 1'b1}) begin bad++; $display("FAIL store_bus: got %h %h %b want 00000100 deadbeef 1", o.a0, o.w0, o.we0); end
    total++; if (o.wb_cyc !== 5 || o.wb_n !== 1 || o.reg_we !== 1'b0) begin bad++; $display("FAIL store_wb: got cyc=%0d n=%0d we=%b want 5 1 0", o.wb_cyc, o.wb_n, o.reg_we); end
  endtask

  task automatic test_load_same_cycle();
    obs_t o;
    drive_txn(2, 32'h0, 4'd9, 32'h0, 32'h0000_0040, 32'h0, 0, 0, 32'h0000_1234, 1'b0, o);
    total++; if (o.wb_cyc !== 2) begin bad++; $display("FAIL load_latency: got %0d want 2", o.wb_cyc); end
    total++; if ({o.reg_we, o.rd, o.data} !== {1'b1, 4'd9, 32'h0000_1234}) begin bad++; $display("FAIL load_wb: got %b %0d %h want 1 9 00001234", o.reg_we, o.rd, o.data); end
    total++; if (o.a0 !== 32'h0000_0040 || o.we0 !== 1'b0) begin bad++; $display("FAIL load_bus: got %h %b want 00000040 0", o.a0, o.we0); end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_txn(2, 32'h0, 4'd2, 32'h0, 32'h0000_0080, 32'h0, 1, -1, 32'h0, 1'b0, o);
    total++; if (o.err_cyc !== TO + 1 || o.err_n !== 1) begin bad++; $display("FAIL timeout_err: got cyc=%0d n=%0d want %0d 1", o.err_cyc, o.err_n, TO + 1); end
    total++; if (o.wb_cyc !== TO + 1 || o.reg_we !== 1'b0) begin bad++; $display("FAIL timeout_wb: got cyc=%0d we=%b want %0d 0", o.wb_cyc, o.reg_we, TO + 1); end
    total++; if (o.ready_end !== 1'b1 || o.req_n !== 2) begin bad++; $display("FAIL timeout_idle: got ready=%b req=%0d want 1 2", o.ready_end, o.req_n); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    drive_txn(2, 32'h0, 4'd1, 32'h0, 32'h0000_0041, 32'h0, 0, 0, 32'h0, 1'b0, o);
    total++; if (o.req_n !== 0) begin bad++; $display("FAIL misaligned_req: got %0d want 0", o.req_n); end
    total++; if (o.err_cyc !== 1 || o.wb_cyc !== 1 || o.reg_we !== 1'b0) begin bad++; $display("FAIL misaligned_pulse: got err=%0d wb=%0d we=%b want 1 1 0", o.err_cyc, o.wb_cyc, o.reg_we); end
  endtask

  task automatic test_random_mem();
    obs_t o;
    exp_t e;
    int cls, gd, rv;
    logic [31:0] addr, rdv, rdat;
    logic [3:0] d;
    for (int i = 0; i < 30; i++) begin
      cls = 2 + int'($urandom_range(0, 1));
      addr = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      gd = int'($urandom_range(0, 9));
      rv = int'($urandom_range(0, 6)) - 1;
      rdv = $urandom; rdat = $urandom; d = 4'($urandom);
      e = model(cls, 32'h0, d, addr, 32'h0, gd, rv, rdat);
      drive_txn(cls, 32'h0, d, rdv, addr, 32'h0, gd, rv, rdat, 1'b0, o);
      total++; if (o.ready_start !== 1'b1 || o.ready_end !== 1'b1) begin bad++; $display("FAIL mem_ready[%0d]: got %b%b want 11", i, o.ready_start, o.ready_end); end
      total++; if (o.wb_cyc !== e.wb_cyc || o.wb_n !== 1) begin bad++; $display("FAIL mem_wb[%0d]: got cyc=%0d n=%0d want cyc=%0d n=1", i, o.wb_cyc, o.wb_n, e.wb_cyc); end
      total++; if (o.err_cyc !== e.err_cyc || o.err_n !== (e.err_cyc > 0 ? 1 : 0)) begin bad++; $display("FAIL mem_err[%0d]: got cyc=%0d n=%0d want cyc=%0d", i, o.err_cyc, o.err_n, e.err_cyc); end
      total++; if (o.req_n !== e.req_n) begin bad++; $display("FAIL mem_req_cycles[%0d]: got %0d want %0d", i, o.req_n, e.req_n); end
      total++; if (o.reg_we !== e.reg_we) begin bad++; $display("FAIL mem_reg_we[%0d]: got %b want %b", i, o.reg_we, e.reg_we); end
      if (e.reg_we) begin
        total++; if ({o.rd, o.data} !== {e.rd, e.data}) begin bad++; $display("FAIL mem_data[%0d]: got %h/%h want %h/%h", i, o.rd, o.data, e.rd, e.data); end
      end
      if (e.req_n > 0) begin
        total++; if (o.a0 !== addr || o.we0 !== (cls == 3) || (cls == 3 && o.w0 !== rdv)) begin bad++; $display("FAIL mem_bus[%0d]: got %h %b %h want %h %b %h", i, o.a0, o.we0, o.w0, addr, (cls == 3), rdv); end
      end
      total++; if (o.unstable || o.leak) begin bad++; $display("FAIL mem_hold[%0d]: got unstable=%b leak=%b want 0 0", i, o.unstable, o.leak); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r [3];
    for (int i = 0; i < 3; i++) begin
      r[i] = $urandom;
      ex_valid = 1'b1; is_alu_op = 1'b1; result = r[i]; rd_num = 4'(i + 1);
      @(posedge clk); #1;
      total++; if ({wb_valid, wb_reg_we, wb_rd_num, wb_data} !== {1'b1, 1'b1, 4'(i + 1), r[i]}) begin bad++; $display("FAIL b2b_wb[%0d]: got %b%b %0d %h want 11 %0d %h", i, wb_valid, wb_reg_we, wb_rd_num, wb_data, i + 1, r[i]); end
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ex_ready); end
    end
    ex_valid = 1'b0; is_alu_op = 1'b0;
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0 || wb_reg_we !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b%b want 00", wb_valid, wb_reg_we); end
  endtask

  task automatic test_reset_in_wait();
    int wb_seen, err_seen;
    ex_valid = 1'b1; is_ld_op = 1'b1; md = 32'h0000_0080; rd_num = 4'd5;
    @(posedge clk); #1;
    ex_valid = 1'b0; is_ld_op = 1'b0;
    total++; if (dmem_bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rstw_req: got %b want 1", dmem_bus.dmem_req); end
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL rstw_busy: got %b want 0", ex_ready); end
    rst = 1'b1;
    #1;
    total++; if (ex_ready !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rstw_immediate: got ready=%b req=%b want 1 0", ex_ready, dmem_bus.dmem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    wb_seen = 0; err_seen = 0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #1;
      dmem_bus.dmem_rvalid = 1'b0;
      if (wb_valid) wb_seen++;
      if (mem_err) err_seen++;
    end
    total++; if (wb_seen !== 0 || err_seen !== 0) begin bad++; $display("FAIL rstw_silent: got wb=%0d err=%0d want 0 0", wb_seen, err_seen); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rstw_idle: got %b want 1", ex_ready); end
  endtask

  initial begin
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_random_simple();
    test_store();
    test_load_same_cycle();
    test_timeout();
    test_misaligned();
    test_random_mem();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
